// File: rtl/data_mem_responder_if.sv
// Core-side load/store bus for the data-memory responder.
// The core drives the strobes and request fields; the responder returns rdata, ready and err.
interface data_mem_responder_if;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic        err;

  modport master (
    output mem_read, mem_write, funct3, addr, wdata,
    input  rdata, ready, err
  );

  modport slave (
    input  mem_read, mem_write, funct3, addr, wdata,
    output rdata, ready, err
  );
endinterface

// File: rtl/data_mem_responder.sv
// Single-outstanding RV32I data memory: accepts a held load/store strobe, completes LATENCY edges later.
// ready pulses for one cycle in DONE; the core must hold its request until then, and new requests wait for IDLE.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic              clk,
  input  logic              rst,
  data_mem_responder_if.slave bus
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cnt;
  logic          op_write;
  logic          op_illegal;
  logic [2:0]    f3_q;
  logic [31:0]   addr_q;
  logic [31:0]   wdata_q;
  logic [31:0]   rdata_q;
  logic          err_q;
  logic [31:0]   mem [DEPTH_WORDS];

  logic          accept;
  logic          complete;
  logic          legal;
  logic          misaligned;
  logic          out_of_range;
  logic          bad;
  logic [AW-1:0] idx;
  logic [31:0]   word;
  logic [31:0]   merged;
  logic [31:0]   load_val;
  logic [7:0]    lane_b;
  logic [15:0]   lane_h;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.mem_read || bus.mem_write) state_nxt = BUSY;
      BUSY:    if (cnt == '0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    accept    = (state == IDLE) && (bus.mem_read || bus.mem_write);
    complete  = (state == BUSY) && (cnt == '0);
    bus.ready = (state == DONE);
    bus.err   = (state == DONE) && err_q;
    bus.rdata = rdata_q;
  end

  // Legality is judged on the captured request so late input changes cannot affect it.
  always_comb begin
    if (op_write) legal = (f3_q == 3'b000) || (f3_q == 3'b001) || (f3_q == 3'b010);
    else          legal = (f3_q == 3'b000) || (f3_q == 3'b001) || (f3_q == 3'b010) ||
                          (f3_q == 3'b100) || (f3_q == 3'b101);
    misaligned   = ((f3_q[1:0] == 2'b01) && addr_q[0]) ||
                   ((f3_q[1:0] == 2'b10) && (addr_q[1:0] != 2'b00));
    out_of_range = |(addr_q >> (AW + 2));
    bad          = op_illegal || !legal || misaligned || out_of_range;
  end

  always_comb begin
    idx    = addr_q[AW+1:2];
    word   = mem[idx];
    lane_b = word[{addr_q[1:0], 3'b000} +: 8];
    lane_h = word[{addr_q[1], 4'b0000} +: 16];

    merged = word;
    case (f3_q[1:0])
      2'b00:   merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
      2'b01:   merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      default: merged = wdata_q;
    endcase

    case (f3_q)
      3'b000:  load_val = {{24{lane_b[7]}}, lane_b};
      3'b001:  load_val = {{16{lane_h[15]}}, lane_h};
      3'b100:  load_val = {24'd0, lane_b};
      3'b101:  load_val = {16'd0, lane_h};
      default: load_val = word;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      op_write   <= 1'b0;
      op_illegal <= 1'b0;
      f3_q       <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      for (int i = 0; i < DEPTH_WORDS; i++) mem[i] <= '0;
    end else begin
      if (accept) begin
        op_write   <= bus.mem_write && !bus.mem_read;
        op_illegal <= bus.mem_read && bus.mem_write;
        f3_q       <= bus.funct3;
        addr_q     <= bus.addr;
        wdata_q    <= bus.wdata;
        cnt        <= CW'(LATENCY - 1);
      end else if ((state == BUSY) && (cnt != '0)) begin
        cnt <= cnt - CW'(1);
      end

      if (complete) begin
        err_q <= bad;
        if (!bad) begin
          if (op_write) mem[idx] <= merged;
          else          rdata_q  <= load_val;
        end
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomised and directed bench for data_mem_responder against a byte-addressed reference memory.
// Three instances with LATENCY 2, 1 and 5 share clock and reset but are driven independently.
module tb_data_mem_responder;

  localparam int ND    = 3;
  localparam int BYTES = 1024;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        rd [ND];
  logic        wr [ND];
  logic [2:0]  f3 [ND];
  logic [31:0] ad [ND];
  logic [31:0] wd [ND];
  wire  [31:0] rq [ND];
  wire         rdy [ND];
  wire         er [ND];

  function automatic int lat_of(input int d);
    return (d == 0) ? 2 : ((d == 1) ? 1 : 5);
  endfunction

  for (genvar g = 0; g < ND; g++) begin : gd
    localparam int L = (g == 0) ? 2 : ((g == 1) ? 1 : 5);
    data_mem_responder_if bus();
    assign bus.mem_read  = rd[g];
    assign bus.mem_write = wr[g];
    assign bus.funct3    = f3[g];
    assign bus.addr      = ad[g];
    assign bus.wdata     = wd[g];
    assign rq[g]  = bus.rdata;
    assign rdy[g] = bus.ready;
    assign er[g]  = bus.err;
    data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(L)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
    );
  end

  byte unsigned mb [ND][BYTES];
  logic [31:0]  last_rd [ND];
  int n_cmp = 0;
  int n_mis = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: observed %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic clear_model();
    for (int d = 0; d < ND; d++) begin
      for (int i = 0; i < BYTES; i++) mb[d][i] = 8'd0;
      last_rd[d] = 32'd0;
    end
  endtask

  // Reference: an access of 1/2/4 bytes on a little-endian byte array.
  task automatic model(input int d, input logic r, input logic w, input logic [2:0] f,
                       input logic [31:0] a, input logic [31:0] wdat,
                       output logic e, output logic [31:0] rdv);
    int sz;
    logic [31:0] v;
    sz = 1 << f[1:0];
    e  = 1'b0;
    if (r && w)                                       e = 1'b1;
    else if (r && !(f inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) e = 1'b1;
    else if (w && !(f inside {3'd0, 3'd1, 3'd2}))     e = 1'b1;
    else if ((a % sz) != 0)                           e = 1'b1;
    else if (a >= BYTES)                              e = 1'b1;
    if (!e) begin
      if (w) begin
        for (int i = 0; i < sz; i++) mb[d][a + i] = wdat[8*i +: 8];
      end else begin
        v = 32'd0;
        for (int i = 0; i < sz; i++) v |= 32'(mb[d][a + i]) << (8 * i);
        if (!f[2] && sz < 4 && v[8*sz-1]) v |= ~((32'd1 << (8 * sz)) - 32'd1);
        last_rd[d] = v;
      end
    end
    rdv = last_rd[d];
  endtask

  task automatic txn(input int d, input logic r, input logic w, input logic [2:0] f,
                     input logic [31:0] a, input logic [31:0] wdat, input bit scramble);
    logic        e;
    logic [31:0] exp;
    int          n;
    model(d, r, w, f, a, wdat, e, exp);
    rd[d] = r; wr[d] = w; f3[d] = f; ad[d] = a; wd[d] = wdat;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
      if (scramble && n == 1) begin
        f3[d] = 3'($urandom);
        ad[d] = $urandom;
        wd[d] = $urandom;
      end
    end while (!rdy[d] && n < 20);
    chk($sformatf("latency d%0d a=%h", d, a), n, lat_of(d) + 1);
    chk($sformatf("err d%0d a=%h f3=%0d", d, a, f), er[d], e);
    chk($sformatf("rdata d%0d a=%h f3=%0d", d, a, f), rq[d], exp);
    rd[d] = 1'b0; wr[d] = 1'b0;
    @(posedge clk); #1;
    chk($sformatf("ready_pulse d%0d", d), {rdy[d], er[d]}, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d compared", n_cmp);
    $fatal(1);
  end

  initial begin
    logic [2:0]  ld_codes [5];
    logic [2:0]  st_codes [3];
    logic [2:0]  f;
    logic [31:0] a;
    logic        e;
    logic [31:0] exp;
    int d, op;

    ld_codes = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    st_codes = '{3'd0, 3'd1, 3'd2};
    for (int i = 0; i < ND; i++) begin
      rd[i] = 1'b0; wr[i] = 1'b0; f3[i] = 3'd0; ad[i] = 32'd0; wd[i] = 32'd0;
    end
    clear_model();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < ND; i++) begin
      chk($sformatf("reset ready d%0d", i), rdy[i], 0);
      chk($sformatf("reset err d%0d", i), er[i], 0);
      chk($sformatf("reset rdata d%0d", i), rq[i], 0);
    end

    // Word store/load, lanes and extension.
    txn(0, 0, 1, 3'b010, 32'h10, 32'hDEADBEEF, 0);
    txn(0, 1, 0, 3'b010, 32'h10, 32'h0, 0);
    txn(0, 0, 1, 3'b010, 32'h20, 32'h8000_00F0, 0);
    txn(0, 1, 0, 3'b000, 32'h20, 32'h0, 0);
    txn(0, 1, 0, 3'b100, 32'h20, 32'h0, 0);
    txn(0, 1, 0, 3'b001, 32'h22, 32'h0, 0);
    txn(0, 1, 0, 3'b101, 32'h22, 32'h0, 0);
    txn(0, 0, 1, 3'b000, 32'h21, 32'h1234_56AB, 0);
    txn(0, 1, 0, 3'b010, 32'h20, 32'h0, 0);
    chk("sb lane merge", last_rd[0], 32'h8000_ABF0);

    // Rejected requests.
    txn(0, 1, 0, 3'b010, 32'h12, 32'h0, 0);
    txn(0, 0, 1, 3'b001, 32'h13, 32'hFFFF_FFFF, 0);
    txn(0, 1, 0, 3'b010, 32'h10, 32'h0, 0);
    txn(0, 1, 1, 3'b010, 32'h10, 32'h0, 0);
    txn(0, 1, 0, 3'b010, 32'h400, 32'h0, 0);
    txn(0, 1, 0, 3'b011, 32'h10, 32'h0, 0);
    txn(0, 0, 1, 3'b100, 32'h10, 32'h5555_5555, 0);
    txn(0, 1, 0, 3'b010, 32'h10, 32'h0, 0);

    // Load strobe held across reset release: completions every LATENCY+2 cycles.
    rst = 1'b1;
    rd[0] = 1'b1; f3[0] = 3'b010; ad[0] = 32'h20;
    @(posedge clk); #1;
    rst = 1'b0;
    clear_model();
    for (int i = 1; i <= 11; i++) begin
      @(posedge clk); #1;
      chk($sformatf("held ready cyc%0d", i), rdy[0], (i >= 3 && ((i - 3) % 4) == 0) ? 1 : 0);
      if (i == 11) rd[0] = 1'b0;
    end
    @(posedge clk); #1;
    chk("held release", rdy[0], 0);

    // Reset during BUSY drops the store.
    wr[0] = 1'b1; f3[0] = 3'b010; ad[0] = 32'h30; wd[0] = 32'h1234;
    @(posedge clk); #1;
    rst = 1'b1; wr[0] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    clear_model();
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk($sformatf("no ready after reset cyc%0d", i), rdy[0], 0);
    end
    txn(0, 1, 0, 3'b010, 32'h30, 32'h0, 0);

    // Other latencies, with request fields disturbed during BUSY.
    for (int k = 1; k < ND; k++) begin
      txn(k, 0, 1, 3'b010, 32'h40, 32'hCAFE_F00D, 1);
      txn(k, 1, 0, 3'b001, 32'h42, 32'h0, 1);
      txn(k, 1, 0, 3'b010, 32'h40, 32'h0, 1);
      txn(k, 1, 0, 3'b010, 32'h41, 32'h0, 1);
    end

    for (int t = 0; t < 300; t++) begin
      d  = $urandom_range(0, ND - 1);
      op = $urandom_range(0, 9);
      a  = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(1000, 1100)) : 32'($urandom_range(0, 63));
      if (op <= 4) f = ($urandom_range(0, 3) != 0) ? st_codes[$urandom_range(0, 2)] : 3'($urandom);
      else         f = ($urandom_range(0, 3) != 0) ? ld_codes[$urandom_range(0, 4)] : 3'($urandom);
      txn(d, (op == 0) || (op > 4), (op <= 4), f, a, $urandom, 1'($urandom));
    end

    // Final sweep: every instance's reference memory versus word reads.
    for (int k = 0; k < ND; k++) begin
      for (int w = 0; w < 16; w++) begin
        model(k, 1, 0, 3'b010, 32'(w * 4), 32'h0, e, exp);
        rd[k] = 1'b1; f3[k] = 3'b010; ad[k] = 32'(w * 4);
        for (int n = 0; n < 20 && !(n > 0 && rdy[k]); n++) begin
          @(posedge clk); #1;
        end
        rd[k] = 1'b0;
        chk($sformatf("sweep d%0d w%0d", k, w), rq[k], exp);
        @(posedge clk); #1;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
